// File: rtl/esaxi_wr_fifo_if.sv
// Handshake bundle between the esaxi write path, the write FIFO and the mesh transmitter.
// The statistics outputs exist only when ESAXI_WR_FIFO_STATS_EN is defined.
interface esaxi_wr_fifo_if #(
    parameter int PW    = 104,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_access;
    logic [PW-1:0] wr_packet;
    logic          wr_wait;
    logic          tx_access;
    logic [PW-1:0] tx_packet;
    logic          tx_wait;
    logic [CW-1:0] count;
`ifdef ESAXI_WR_FIFO_STATS_EN
    logic [31:0]   pkt_cnt;
    logic [15:0]   stall_cnt;
    logic [CW-1:0] hwm;

    modport slave  (input  wr_access, wr_packet, tx_wait,
                    output wr_wait, tx_access, tx_packet, count, pkt_cnt, stall_cnt, hwm);
    modport master (output wr_access, wr_packet, tx_wait,
                    input  wr_wait, tx_access, tx_packet, count, pkt_cnt, stall_cnt, hwm);
`else
    modport slave  (input  wr_access, wr_packet, tx_wait,
                    output wr_wait, tx_access, tx_packet, count);
    modport master (output wr_access, wr_packet, tx_wait,
                    input  wr_wait, tx_access, tx_packet, count);
`endif
endinterface

// File: rtl/esaxi_wr_fifo.sv
// Registered-output write FIFO from esaxi toward the emesh, no fall-through path.
// Optional statistics counters are enabled with the macro ESAXI_WR_FIFO_STATS_EN.
module esaxi_wr_fifo #(
    parameter int PW    = 104,
    parameter int DEPTH = 4
) (
    input  logic          s_axi_aclk,
    input  logic          s_axi_aresetn,
    esaxi_wr_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    // Flags come only from registered occupancy, so wr_wait never depends on wr_access.
    assign w_full = (r_count == FULL_CNT);
    assign w_push = bus.wr_access & ~w_full;
    assign w_pop  = (r_count != '0) & ~bus.tx_wait;

    assign bus.wr_wait   = w_full;
    assign bus.tx_access = (r_count != '0);
    assign bus.tx_packet = r_mem[r_rptr];
    assign bus.count     = r_count;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage carries no reset; stale entries are masked by tx_access.
    always_ff @(posedge s_axi_aclk) begin
        if (w_push) r_mem[r_wptr] <= bus.wr_packet;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

`ifdef ESAXI_WR_FIFO_STATS_EN
    logic [31:0]   r_pkt_cnt;
    logic [15:0]   r_stall_cnt;
    logic [CW-1:0] r_hwm;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
            r_hwm       <= '0;
        end else begin
            if (w_pop)                     r_pkt_cnt   <= r_pkt_cnt + 32'd1;
            if (bus.wr_access && w_full)   r_stall_cnt <= sat_inc16(r_stall_cnt);
            if (w_count_nxt > r_hwm)       r_hwm       <= w_count_nxt;
        end
    end

    assign bus.pkt_cnt   = r_pkt_cnt;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.hwm       = r_hwm;
`endif

endmodule

// File: tb/tb_esaxi_wr_fifo.sv
// Directed and randomized bench for esaxi_wr_fifo against a queue-based reference model.
module tb_esaxi_wr_fifo;
    localparam int PW    = 104;
    localparam int DEPTH = 4;

    logic s_axi_aclk    = 1'b0;
    logic s_axi_aresetn = 1'b0;

    esaxi_wr_fifo_if #(.PW(PW), .DEPTH(DEPTH)) bus ();

    esaxi_wr_fifo #(.PW(PW), .DEPTH(DEPTH)) dut (
        .s_axi_aclk   (s_axi_aclk),
        .s_axi_aresetn(s_axi_aresetn),
        .bus          (bus)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    logic [PW-1:0] q    [$];
    logic [PW-1:0] got  [$];
    logic [PW-1:0] sent [$];
    int n_err = 0;
    int n_chk = 0;
    int m_pkt = 0;
    int m_stall = 0;
    int m_hwm = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 128'(bus.count), 128'(q.size()));
        chk("tx_access", 128'(bus.tx_access), 128'(q.size() != 0));
        chk("wr_wait", 128'(bus.wr_wait), 128'(q.size() == DEPTH));
        if (q.size() != 0) chk("tx_packet", 128'(bus.tx_packet), 128'(q[0]));
`ifdef ESAXI_WR_FIFO_STATS_EN
        chk("pkt_cnt", 128'(bus.pkt_cnt), 128'(m_pkt));
        chk("stall_cnt", 128'(bus.stall_cnt), 128'(m_stall));
        chk("hwm", 128'(bus.hwm), 128'(m_hwm));
`endif
    endtask

    // One clock: drive inputs between edges, update the model at the edge, check on the falling edge.
    task automatic step(input logic acc, input logic [PW-1:0] pkt, input logic tw, output logic pushed);
        logic m_push, m_pop;
        bus.wr_access = acc;
        bus.wr_packet = pkt;
        bus.tx_wait   = tw;
        m_push = acc && (q.size() < DEPTH);
        m_pop  = (q.size() != 0) && !tw;
        if (acc && q.size() == DEPTH && m_stall < 16'hFFFF) m_stall++;
        if (m_pop) got.push_back(bus.tx_packet);
        @(posedge s_axi_aclk);
        if (m_pop) begin
            void'(q.pop_front());
            m_pkt++;
        end
        if (m_push) q.push_back(pkt);
        if (q.size() > m_hwm) m_hwm = q.size();
        pushed = m_push;
        @(negedge s_axi_aclk);
        #1;
        check_state();
    endtask

    task automatic drain();
        logic p;
        int cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            step(1'b0, '0, 1'b0, p);
            cyc++;
        end
        chk("drain_empty", 128'(bus.tx_access), 128'(0));
    endtask

    task automatic reset_mid();
        @(negedge s_axi_aclk);
        #2 s_axi_aresetn = 1'b0;
        #1;
        q.delete();
        m_pkt = 0; m_stall = 0; m_hwm = 0;
        check_state();
        @(negedge s_axi_aclk);
        #1 s_axi_aresetn = 1'b1;
    endtask

    function automatic logic [PW-1:0] rnd_pkt();
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        return v[PW-1:0];
    endfunction

    initial begin
        logic p;
        logic [PW-1:0] pk;
        int idx, cyc;

        bus.wr_access = 1'b0;
        bus.wr_packet = '0;
        bus.tx_wait   = 1'b0;
        #1;
        check_state();
        @(negedge s_axi_aclk);
        #1 s_axi_aresetn = 1'b1;

        // Single packet with one-cycle latency
        pk = {13{8'hA5}};
        got.delete();
        step(1'b1, pk, 1'b0, p);
        chk("single_access", 128'(bus.tx_access), 128'(1));
        chk("single_packet", 128'(bus.tx_packet), 128'(pk));
        step(1'b0, '0, 1'b0, p);
        chk("single_count0", 128'(bus.count), 128'(0));
        chk("single_got", 128'(got[0]), 128'(pk));

        // Fill to full, hold P4 under backpressure, then drain
        got.delete(); sent.delete();
        for (int i = 0; i < 5; i++) sent.push_back(rnd_pkt());
        for (int i = 0; i < 4; i++) step(1'b1, sent[i], 1'b1, p);
        chk("fill_wr_wait", 128'(bus.wr_wait), 128'(1));
        chk("fill_count", 128'(bus.count), 128'(DEPTH));
        step(1'b1, sent[4], 1'b1, p);
        chk("fill_p4_blocked", 128'(p), 128'(0));
        step(1'b1, sent[4], 1'b0, p);
        chk("fill_pop_no_push", 128'(bus.count), 128'(3));
        step(1'b1, sent[4], 1'b0, p);
        chk("fill_p4_taken", 128'(p), 128'(1));
        drain();
        chk("fill_n", 128'(got.size()), 128'(5));
        for (int i = 0; i < 5 && i < got.size(); i++) chk("fill_order", 128'(got[i]), 128'(sent[i]));

        // Simultaneous push and pop at count 2
        got.delete(); sent.delete();
        for (int i = 0; i < 3; i++) sent.push_back(rnd_pkt());
        step(1'b1, sent[0], 1'b1, p);
        step(1'b1, sent[1], 1'b1, p);
        step(1'b1, sent[2], 1'b0, p);
        chk("simul_count", 128'(bus.count), 128'(2));
        drain();
        chk("simul_n", 128'(got.size()), 128'(3));
        for (int i = 0; i < 3 && i < got.size(); i++) chk("simul_order", 128'(got[i]), 128'(sent[i]));

        // Wrap-around stream with random backpressure
        got.delete(); sent.delete();
        for (int i = 0; i < 20; i++) sent.push_back(rnd_pkt());
        idx = 0; cyc = 0;
        while (idx < 20 && cyc < 400) begin
            step(1'b1, sent[idx], 1'($urandom_range(0, 1)), p);
            if (p) idx++;
            cyc++;
        end
        chk("wrap_accepted", 128'(idx), 128'(20));
        drain();
        chk("wrap_n", 128'(got.size()), 128'(20));
        for (int i = 0; i < 20 && i < got.size(); i++) chk("wrap_order", 128'(got[i]), 128'(sent[i]));

        // Reset mid-operation with three packets buffered
        for (int i = 0; i < 3; i++) step(1'b1, rnd_pkt(), 1'b1, p);
        chk("pre_reset_count", 128'(bus.count), 128'(3));
        reset_mid();
        got.delete();
        pk = rnd_pkt();
        step(1'b1, pk, 1'b1, p);
        chk("post_reset_push", 128'(bus.count), 128'(1));
        chk("post_reset_head", 128'(bus.tx_packet), 128'(pk));
        drain();
        chk("post_reset_n", 128'(got.size()), 128'(1));

`ifdef ESAXI_WR_FIFO_STATS_EN
        reset_mid();
        for (int i = 0; i < 4; i++) step(1'b1, rnd_pkt(), 1'b1, p);
        for (int i = 0; i < 3; i++) step(1'b1, rnd_pkt(), 1'b1, p);
        drain();
        for (int i = 0; i < 6; i++) step(1'b1, rnd_pkt(), 1'b0, p);
        drain();
        chk("stats_pkt", 128'(bus.pkt_cnt), 128'(10));
        chk("stats_stall", 128'(bus.stall_cnt), 128'(3));
        chk("stats_hwm", 128'(bus.hwm), 128'(4));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
